// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding for the countdown timer
package countdown_pkg;
    typedef enum logic [1:0] {CT_IDLE, CT_RUN, CT_DONE} ct_state_t;
endpackage

// File: rtl/countdown_reg.sv
// countdown_reg: count register with clear/load/decrement controls and a q==1 detect
module countdown_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] q_o,
    output logic             is_one_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    // clear wins over load, load wins over decrement
    always_comb cnt_d = clr_i ? '0 : load_i ? load_val_i : dec_i ? cnt_q - WIDTH'(1) : cnt_q;
    // count register, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign q_o      = cnt_q;
    assign is_one_o = cnt_q == WIDTH'(1);
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with terminal-count pulse and optional auto-reload
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             en,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);
    ct_state_t        state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q;
    logic             load, dec, clr, is_one;
    logic [WIDTH-1:0] load_val;
    // next state and counter controls; loads come from the port in IDLE, from reload_q in DONE
    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        load     = 1'b0;
        dec      = 1'b0;
        clr      = 1'b0;
        load_val = state_q == CT_IDLE ? load_value : reload_q;
        case (state_q)
            CT_IDLE: if (load_valid) begin
                load     = 1'b1;
                reload_d = load_value;
                state_d  = load_value != '0 ? CT_RUN : CT_DONE;
            end
            CT_RUN: if (abort) begin
                clr     = 1'b1;
                state_d = CT_IDLE;
            end else if (en) begin
                dec     = 1'b1;
                state_d = is_one ? CT_DONE : CT_RUN;
            end
            CT_DONE: if (abort || !auto_reload) begin
                state_d = CT_IDLE;
            end else if (reload_q != '0) begin
                load    = 1'b1;
                state_d = CT_RUN;
            end
            default: state_d = CT_IDLE;
        endcase
    end
    // state, reload value and done flag; done is high for exactly the cycles spent in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= CT_IDLE;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            done_q   <= state_d == CT_DONE;
        end
    end
    countdown_reg #(.WIDTH(WIDTH)) u_reg (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .load_val_i(load_val),
        .dec_i     (dec),
        .clr_i     (clr),
        .q_o       (q),
        .is_one_o  (is_one)
    );
    assign busy       = state_q != CT_IDLE;
    assign load_ready = state_q == CT_IDLE;
    assign done       = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed table, corner sequences and randomized model check
module tb_countdown_timer;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid, en, auto_reload, abort;
    logic [W-1:0] load_value;
    logic         load_ready, busy, done;
    logic [W-1:0] q;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        logic         lv;
        logic [W-1:0] val;
        logic         en, ar, ab;
        int           want_q;
        logic         want_busy, want_done;
    } vec_t;
    vec_t vecs[$];
    int   m_q, m_n;
    bit   m_busy, m_done;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .en         (en),
        .auto_reload(auto_reload),
        .abort      (abort),
        .q          (q),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic outs(input string tag, input int wq, input bit wb, input bit wd);
        chk({tag, ".q"}, 32'(q), wq);
        chk({tag, ".busy"}, 32'(busy), 32'(wb));
        chk({tag, ".done"}, 32'(done), 32'(wd));
        chk({tag, ".load_ready"}, 32'(load_ready), 32'(!wb));
    endtask

    task automatic cyc(input bit lv, input int val, input bit e, input bit ar, input bit ab);
        load_valid  = lv;
        load_value  = W'(val);
        en          = e;
        auto_reload = ar;
        abort       = ab;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit lv, int val, bit e, bit ar, bit ab, int wq, bit wb, bit wd);
        vec_t v;
        v.lv = lv; v.val = W'(val); v.en = e; v.ar = ar; v.ab = ab;
        v.want_q = wq; v.want_busy = wb; v.want_done = wd;
        return v;
    endfunction

    // reference: one cycle of the timer described as (busy, at-terminal) flags plus plain arithmetic
    function automatic void m_step(bit lv, int val, bit e, bit ar, bit ab);
        if (!m_busy) begin
            if (lv) begin
                m_q = val; m_n = val; m_busy = 1; m_done = (val == 0);
            end
        end else if (m_done) begin
            if (ab || !ar) begin
                m_busy = 0; m_done = 0;
            end else if (m_n != 0) begin
                m_q = m_n; m_done = 0;
            end
        end else if (ab) begin
            m_q = 0; m_busy = 0;
        end else if (e) begin
            m_q = m_q - 1;
            m_done = (m_q == 0);
        end
    endfunction

    initial begin
        reset = 1'b0; load_valid = 0; load_value = '0; en = 0; auto_reload = 0; abort = 0;
        #1;
        outs("reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        // basic N=3
        vecs.push_back(mk(1,3,1,0,0, 3,1,0));
        vecs.push_back(mk(0,0,1,0,0, 2,1,0));
        vecs.push_back(mk(0,0,1,0,0, 1,1,0));
        vecs.push_back(mk(0,0,1,0,0, 0,1,1));
        vecs.push_back(mk(0,0,1,0,0, 0,0,0));
        // enable gap at q=2
        vecs.push_back(mk(1,4,1,0,0, 4,1,0));
        vecs.push_back(mk(0,0,1,0,0, 3,1,0));
        vecs.push_back(mk(0,0,1,0,0, 2,1,0));
        vecs.push_back(mk(0,0,0,0,0, 2,1,0));
        vecs.push_back(mk(0,0,0,0,0, 2,1,0));
        vecs.push_back(mk(0,0,1,0,0, 1,1,0));
        vecs.push_back(mk(0,0,1,0,0, 0,1,1));
        vecs.push_back(mk(0,0,1,0,0, 0,0,0));
        // auto-reload N=2, then drop it
        vecs.push_back(mk(1,2,1,1,0, 2,1,0));
        vecs.push_back(mk(0,0,1,1,0, 1,1,0));
        vecs.push_back(mk(0,0,1,1,0, 0,1,1));
        vecs.push_back(mk(0,0,1,1,0, 2,1,0));
        vecs.push_back(mk(0,0,1,1,0, 1,1,0));
        vecs.push_back(mk(0,0,1,1,0, 0,1,1));
        vecs.push_back(mk(0,0,1,0,0, 0,0,0));
        // N=0, and N=0 with auto_reload holding DONE
        vecs.push_back(mk(1,0,0,0,0, 0,1,1));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0));
        vecs.push_back(mk(1,0,0,1,0, 0,1,1));
        vecs.push_back(mk(0,0,0,1,0, 0,1,1));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0));
        // abort beats en at q=3
        vecs.push_back(mk(1,5,1,0,0, 5,1,0));
        vecs.push_back(mk(0,0,1,0,0, 4,1,0));
        vecs.push_back(mk(0,0,1,0,0, 3,1,0));
        vecs.push_back(mk(0,0,1,0,1, 0,0,0));
        // abort ignored in IDLE; load ignored in RUN
        vecs.push_back(mk(1,6,0,0,1, 6,1,0));
        vecs.push_back(mk(1,9,0,0,0, 6,1,0));
        vecs.push_back(mk(1,9,1,0,0, 5,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,0));
        // abort in DONE with auto_reload
        vecs.push_back(mk(1,1,1,1,0, 1,1,0));
        vecs.push_back(mk(0,0,1,1,0, 0,1,1));
        vecs.push_back(mk(0,0,1,1,1, 0,0,0));
        foreach (vecs[i]) begin
            cyc(vecs[i].lv, int'(vecs[i].val), vecs[i].en, vecs[i].ar, vecs[i].ab);
            outs($sformatf("vec%0d", i), vecs[i].want_q, vecs[i].want_busy, vecs[i].want_done);
        end
        // asynchronous reset mid-count, no clock edge
        cyc(1, 5, 0, 0, 0);
        outs("pre_rst", 5, 1, 0);
        #2 reset = 1'b0;
        #1;
        outs("async_rst", 0, 0, 0);
        #1 reset = 1'b1;
        cyc(0, 0, 1, 0, 0);
        outs("post_rst", 0, 0, 0);
        // full-scale count, no wrap
        cyc(1, 15, 1, 0, 0);
        outs("n15_load", 15, 1, 0);
        for (int k = 14; k >= 0; k--) begin
            cyc(0, 0, 1, 0, 0);
            outs($sformatf("n15_q%0d", k), k, 1, k == 0);
        end
        cyc(0, 0, 1, 0, 0);
        outs("n15_end", 0, 0, 0);
        // randomized against the reference
        m_q = 0; m_n = 0; m_busy = 0; m_done = 0;
        for (int i = 0; i < 1500; i++) begin
            automatic bit lv = ($urandom % 4) == 0;
            automatic int val = int'($urandom % 16);
            automatic bit e = ($urandom % 4) != 0;
            automatic bit ar = ($urandom % 2) == 1;
            automatic bit ab = ($urandom % 16) == 0;
            m_step(lv, val, e, ar, ab);
            cyc(lv, val, e, ar, ab);
            outs($sformatf("rnd%0d", i), m_q, m_busy, m_done);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
